// File: rtl/polar_pkg.sv
// Shared polar-code helpers: FSM states, constant clog2, bit reversal, stage counter width.
package polar_pkg;
  typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Reverse the low w bits of i.
  function automatic int bitrev(input int i, input int w);
    int r;
    r = 0;
    for (int b = 0; b < w; b++) r |= ((i >> b) & 1) << (w - 1 - b);
    return r;
  endfunction

  // Counter must reach log2(N) so stage indices never wrap.
  function automatic int stage_w(input int n);
    int w;
    w = clog2(clog2(n) + 1);
    return (w < 1) ? 1 : w;
  endfunction
endpackage

// File: rtl/polar_encoder_if.sv
// Message-in / codeword-out valid-ready bus of the polar encoder.
interface polar_encoder_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_u;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_x;

  modport slave (input in_valid, in_u, out_ready, output in_ready, out_valid, out_x);
  modport master(output in_valid, in_u, out_ready, input in_ready, out_valid, out_x);
endinterface

// File: rtl/polar_enc_stage.sv
// One butterfly stage: lanes with bit s clear fold in their partner at i + 2^s.
module polar_enc_stage
  import polar_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]            v,
  input  logic [stage_w(N)-1:0]   s,
  output logic [N-1:0]            v_next
);
  localparam int LOGN = clog2(N);
  localparam int SW   = stage_w(N);

  for (genvar i = 0; i < N; i++) begin : g_lane
    // One candidate partner per possible stage value; unused slots read as zero.
    logic [2**SW-1:0] xr;
    for (genvar k = 0; k < 2**SW; k++) begin : g_k
      if (k < LOGN && ((i >> k) & 1) == 0) begin : g_on
        assign xr[k] = v[i + (1 << k)];
      end else begin : g_off
        assign xr[k] = 1'b0;
      end
    end
    assign v_next[i] = v[i] ^ xr[s];
  end
endmodule

// File: rtl/polar_encoder.sv
// Iterative polar encoder: one butterfly stage per cycle, IDLE/ENCODE/DONE handshake.
// Define POLAR_ENC_BITREV_EN to emit the codeword in bit-reversed index order.
module polar_encoder
  import polar_pkg::*;
#(
  parameter int           N           = 8,
  parameter logic [N-1:0] FROZEN_MASK = 8'b0001_0111
) (
  input  logic          clk,
  input  logic          rst_n,
  polar_encoder_if.slave bus
);
  localparam int LOGN = clog2(N);
  localparam int SW   = stage_w(N);

  state_t        state, state_nx;
  logic [N-1:0]  v, v_next, xo;
  logic [SW-1:0] s;

  polar_enc_stage #(.N(N)) u_stage (
    .v      (v),
    .s      (s),
    .v_next (v_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      v     <= '0;
      s     <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (bus.in_valid) begin
          v <= bus.in_u & ~FROZEN_MASK;
          s <= '0;
        end
        ENCODE: begin
          v <= v_next;
          s <= s + SW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx     = state;
    bus.in_ready = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nx = ENCODE;
      end
      ENCODE: if (s == SW'(LOGN - 1)) state_nx = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  for (genvar i = 0; i < N; i++) begin : g_out
`ifdef POLAR_ENC_BITREV_EN
    assign xo[i] = v[LOGN'(bitrev(i, LOGN))];
`else
    assign xo[i] = v[i];
`endif
  end

  // Partial sums are never exposed; out_x reads zero outside DONE.
  assign bus.out_x = (state == DONE) ? xo : '0;
endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder: directed cases, reset abort, random traffic vs model.
module tb_polar_encoder;
  localparam int           N    = 8;
  localparam int           LOGN = 3;
  localparam logic [N-1:0] MASK = 8'b0001_0111;

  logic clk, rst_n;
  int   n_chk, n_pass;

  polar_encoder_if #(.N(N)) bus();

  polar_encoder #(.N(N), .FROZEN_MASK(MASK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // x[i] = XOR of free u[j] over all supersets j of i, optionally bit-reversed.
  function automatic logic [N-1:0] ref_x(input logic [N-1:0] u);
    logic [N-1:0] m, x, o;
    int r;
    m = u & ~MASK;
    x = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if ((j & i) == i) x[i] = x[i] ^ m[j];
`ifdef POLAR_ENC_BITREV_EN
    for (int i = 0; i < N; i++) begin
      r = 0;
      for (int b = 0; b < LOGN; b++) if (i & (1 << b)) r += 1 << (LOGN - 1 - b);
      o[i] = x[r];
    end
`else
    o = x;
`endif
    return o;
  endfunction

  task automatic run_one(input string tag, input logic [N-1:0] u, input logic [N-1:0] exp,
                         input int hold);
    int lat;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_u      = u;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_u     = N'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
      step();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LOGN + 1));
    chk({tag, "_x"}, 32'(bus.out_x), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_u     = N'($urandom);
      step();
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_x"}, 32'(bus.out_x), 32'(exp));
      chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [N-1:0] q[$];
    logic [N-1:0] exp08, e;
    int sent, got, cyc, seen;
    bit hs_in, hs_out;

    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_u = '0; bus.out_ready = 1'b0;
    #1;
    repeat (3) step();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_x", 32'(bus.out_x), 32'd0);
    rst_n = 1'b1;
    step();

`ifdef POLAR_ENC_BITREV_EN
    exp08 = 8'h55;
`else
    exp08 = 8'h0F;
`endif
    run_one("u80", 8'h80, 8'hFF, 0);
    run_one("u08", 8'h08, exp08, 0);
    run_one("u17", 8'h17, 8'h00, 0);
    run_one("hold", 8'h80, 8'hFF, 10);
    e = 8'hE8;
    run_one("uE8", e, ref_x(e), 2);

    // Reset during ENCODE stage 1 discards the codeword.
    bus.in_valid = 1'b1; bus.in_u = 8'hFF;
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_out_x", 32'(bus.out_x), 32'd0);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.out_valid) seen++;
    end
    chk("abort_no_emit", 32'(seen), 32'd0);
    bus.out_ready = 1'b0;

    // Random traffic with gaps on both sides; scoreboard in arrival order.
    sent = 0; got = 0; cyc = 0;
    while (got < 100 && cyc < 5000) begin
      bus.in_valid  = (sent < 100) && ($urandom_range(0, 2) != 0);
      bus.in_u      = N'($urandom);
      bus.out_ready = $urandom_range(0, 1) == 1;
      #0;
      hs_in  = bus.in_valid && bus.in_ready;
      hs_out = bus.out_valid && bus.out_ready;
      if (hs_out) begin
        if (q.size() == 0) chk("rand_unexpected", 32'(bus.out_x), 32'hFFFF_FFFF);
        else chk("rand_x", 32'(bus.out_x), 32'(q.pop_front()));
        got++;
      end
      if (hs_in) begin
        q.push_back(ref_x(bus.in_u));
        sent++;
      end
      step();
      cyc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    chk("rand_count", 32'(got), 32'd100);
    chk("rand_sent", 32'(sent), 32'd100);
    chk("rand_leftover", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/polar_encoder.md
POLAR_ENCODER -- requirements
Module: polar_encoder

Interface
REQ-001 SHALL have parameter N, default 8, meaning the codeword length; legal values are powers of two, N >= 2.
REQ-002 SHALL have parameter FROZEN_MASK, N bits, default 8'b0001_0111, meaning bit i = 1 marks u[i] as frozen.
REQ-003 SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, the reset; reset is synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit, asserted when in_u is valid.
REQ-006 SHALL have port in_ready, output, 1 bit, asserted when the block accepts in_u.
REQ-007 SHALL have port in_u, input, N bits, the message vector u (index 0 = LSB).
REQ-008 SHALL have port out_valid, output, 1 bit, asserted when out_x holds a finished codeword.
REQ-009 SHALL have port out_ready, input, 1 bit, asserted when the downstream decoder side accepts out_x.
REQ-010 SHALL have port out_x, output, N bits, the codeword x.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, ENCODE, DONE.
REQ-012 SHALL drive in_ready = 1 only in IDLE, and out_valid = 1 only in DONE.
REQ-013 SHALL, on in_valid && in_ready, load the working register with in_u & ~FROZEN_MASK, clear the stage counter to 0, and enter ENCODE.
REQ-014 SHALL, in each ENCODE cycle with stage s, update every index i having bit s = 0 as v[i] <= v[i] ^ v[i + 2^s], leave the other indices unchanged, and increment s.
REQ-015 SHALL use a stage counter of width max(1, clog2(clog2(N)+1)) and enter DONE after stage log2(N)-1 is applied.
REQ-016 SHALL assert out_valid exactly log2(N)+1 cycles after the input-handshake edge: 4 cycles for N = 8.
REQ-017 SHALL hold out_x and out_valid stable in DONE until out_ready = 1, then return to IDLE on that edge.
REQ-018 SHALL NOT accept input in the cycle of an output handshake; the minimum per-codeword period is log2(N)+2 cycles.
REQ-019 SHALL ignore in_valid outside IDLE; in_u changes during ENCODE or DONE SHALL NOT affect the result.
REQ-020 SHALL ignore out_ready outside DONE.
REQ-021 SHALL compute x bit-exactly over GF(2) with no arithmetic widening: x[i] = XOR of u[j] over all j with (j & i) == i.

Reset
REQ-022 SHALL, when rst_n = 0 at a clock edge, enter IDLE, clear the working register and stage counter, and drive in_ready = 1, out_valid = 0, out_x = 0 from the next cycle.
REQ-023 SHALL make reset override all activity, including reset during ENCODE or DONE; any in-flight codeword is discarded without an output handshake.

Configuration
REQ-024 SHALL support macro POLAR_ENC_BITREV_EN; when it is defined, out_x[i] SHALL equal x[bitrev_log2N(i)].
REQ-025 SHALL, without POLAR_ENC_BITREV_EN, output natural order out_x[i] = x[i]; latency and handshake SHALL be identical in both builds.

Structure
REQ-026 SHALL take the FSM state enum, a constant clog2 function, and a bit-reverse function from shared package polar_pkg, reused by the decoder side.
REQ-027 SHALL place the single butterfly stage as combinational sub-module polar_enc_stage, with inputs v and s and output v_next.

Verification
REQ-028 SHALL cover (N = 8, default mask, natural order): in_u = 8'h80 -> out_x = 8'hFF, with out_valid on the 4th cycle after the handshake.
REQ-029 SHALL cover: in_u = 8'h08 -> out_x = 8'h0F; with POLAR_ENC_BITREV_EN defined -> out_x = 8'h55.
REQ-030 SHALL cover: in_u = 8'h17 (frozen bits only) -> out_x = 8'h00.
REQ-031 SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_x and out_valid stable, in_ready = 0 throughout, and one handshake when out_ready rises.
REQ-032 SHALL cover: rst_n = 0 during ENCODE stage 1 -> next cycle in_ready = 1, out_valid = 0, out_x = 0, and no codeword emitted.
REQ-033 SHALL cover: 100 random in_u values with random in_valid/out_ready gaps -> every out_x matches the REQ-021 reference model, in order, with none lost or duplicated.
